dest_hazard_track: RTL
======================

# dest_hazard_track

Tracks the destination register number produced by the ID-stage rt/rd select mux through the EX, MEM and WB stages of the MIPS 54-instruction pipeline. Every cycle it compares the ID-stage source operands against in-flight destinations to produce operand-forwarding selects and a pipeline stall. It holds a countdown for multi-cycle DIV/DIVU so that HI/LO readers stall until the result is ready. It sits between the decode-stage destination mux and the hazard-control inputs of the PC, IF/ID and ID/EX registers.

## Interface
- DIV_LAT, 32, cycles DIV/DIVU occupies the HI/LO unit after entering EX (≥2)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- id_dest  in  5  destination register number selected in ID
- id_wen  in  1  ID instruction writes a GPR
- id_is_load  in  1  ID instruction is LB/LBU/LH/LHU/LW
- id_is_div  in  1  ID instruction is DIV/DIVU
- id_uses_hilo  in  1  ID instruction reads HI/LO (MFHI/MFLO) or is DIV/DIVU/MULT/MULTU
- id_rs, id_rt  in  5 each  ID source register numbers
- id_use_rs, id_use_rt  in  1 each  ID instruction actually reads rs / rt
- flush  in  1  synchronous: kill the ID instruction (branch/exception redirect)
- stall  out  1  hold PC and IF/ID; insert bubble into EX
- fwd_a, fwd_b  out  2 each  source select for rs / rt: 00 regfile, 01 EX result, 10 MEM result, 11 WB result
- div_busy  out  1  divider countdown non-zero
- ex_dest, mem_dest, wb_dest  out  5 each  tracked destination per stage
- wb_wen  out  1  WB stage writes the register file

## Operation
- Internal stage records EX, MEM, WB: {dest[4:0], wen, load}. Each cycle: WB←MEM, MEM←EX, EX←ID-or-bubble.
- EX receives a bubble (dest=0, wen=0, load=0) when stall=1 or flush=1; otherwise {id_dest, id_wen, id_is_load}.
- A record with dest=0 never matches (writes to $0 are discarded); matching requires wen=1 and dest≠0.
- Load-use: stall=1 if EX.load=1 and EX matches id_rs (with id_use_rs) or id_rt (with id_use_rt).
- HI/LO: stall=1 if div_busy=1 and id_uses_hilo=1.
- stall is the OR of both conditions; it is combinational from the current records, the counter and the ID inputs.
- Forwarding per operand (rs→fwd_a, rt→fwd_b), priority youngest first:
  - EX match and EX.load=0 → 01.
  - else MEM match → 10 (load data is valid at MEM output).
  - else WB match → 11.
  - else 00.
  - An operand whose use flag is 0 gets 00.
  - While stall=1, fwd values are don't-care.
- Divider counter, width clog2(DIV_LAT+1):
  - Loads DIV_LAT on the clock edge where a DIV enters EX (id_is_div=1, stall=0, flush=0).
  - Otherwise decrements by 1 while non-zero; saturates at 0.
  - div_busy = (count≠0).
- flush does not affect MEM, WB or a counter already running.
- stall and flush together: EX gets a bubble and the counter does not load; stall is still driven by its own conditions.

## Timing
- Reset (async, rst_n=0): all records cleared to 0, count=0. Outputs: stall=0, fwd_a=fwd_b=00, div_busy=0, ex_dest=mem_dest=wb_dest=0, wb_wen=0. Release is synchronous to the next clk edge.
- Reset asserted mid-division clears the counter immediately.
- Load-use costs exactly one stall cycle. The next cycle the load is in MEM and fwd=10.
- A DIV entering EX at edge N sets div_busy=1 from N through N+DIV_LAT−1 and 0 from edge N+DIV_LAT.
- All outputs are valid combinationally within the same cycle as the ID inputs. There is no extra output register.

## Test plan
- Reset: hold rst_n=0 with arbitrary inputs → all outputs 0; release, then idle 3 cycles → still 0.
- Back-to-back ALU chain: ADDU dest 8, then ADDU rs=8 → fwd_a=01; insert one unrelated instruction → 10; insert two → 11; insert three → 00.
- Load-use: LW dest 9, then ADD rt=9 → stall=1 for exactly one cycle, ex_dest=0 in the bubble cycle, then fwd_b=10, stall=0.
- $0 and unused operands: LW dest 0, then rs=0 → stall=0, fwd_a=00; LW dest 5, then rs=5 with id_use_rs=0 → stall=0.
- Divider, DIV_LAT=4: DIV, then MFLO → stall=1 for 4 cycles, div_busy falls on the 4th edge, MFLO issues on the next cycle; repeat with rst_n pulsed low mid-count → div_busy=0 immediately.
- Flush: flush=1 with id_is_div=1 and id_wen=1 dest 3 → EX bubble, div_busy stays 0, and a following rs=3 sees fwd_a=00.

Source files
------------

// File: rtl/dest_hazard_track.sv
// dest_hazard_track
//   Follows the GPR destination of each instruction through EX, MEM and WB.
//   From that it produces the rs/rt operand-forwarding selects and the
//   load-use / HI-LO stall for the ID stage. It also runs a countdown that
//   covers the multi-cycle DIV/DIVU latency.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   id_dest, id_wen            destination and write enable of the ID instruction
//   id_is_load, id_is_div      ID instruction class
//   id_uses_hilo               ID instruction reads or writes HI/LO
//   id_rs, id_rt               ID source registers
//   id_use_rs, id_use_rt       the source is actually read
//   flush                      kill the ID instruction (EX gets a bubble)
//   stall                      hold PC, IF/ID and put a bubble into EX
//   fwd_a, fwd_b               00 regfile, 01 EX, 10 MEM, 11 WB
//   div_busy                   divider countdown is non-zero
//   ex_dest, mem_dest, wb_dest tracked destination per stage
//   wb_wen                     WB stage writes the register file
module dest_hazard_track #(
    parameter int DIV_LAT = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] id_dest,
    input  logic       id_wen,
    input  logic       id_is_load,
    input  logic       id_is_div,
    input  logic       id_uses_hilo,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_use_rs,
    input  logic       id_use_rt,
    input  logic       flush,
    output logic       stall,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b,
    output logic       div_busy,
    output logic [4:0] ex_dest,
    output logic [4:0] mem_dest,
    output logic [4:0] wb_dest,
    output logic       wb_wen
);

    localparam int CW = $clog2(DIV_LAT + 1);
    localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_LAT);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef struct packed {
        logic [4:0] dest;
        logic       wen;
        logic       load;
    } rec_t;

    rec_t          ex_q, mem_q, wb_q;
    rec_t          ex_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          load_use, hilo_wait, div_start;

    // Writes to $0 are discarded, so a $0 destination never produces a hazard.
    function automatic logic hit(input rec_t r, input logic [4:0] src);
        return r.wen && (r.dest != 5'd0) && (r.dest == src);
    endfunction

    // Youngest producer wins. A load in EX has no data yet. That case is
    // covered by the load-use stall, so EX is skipped and the select falls
    // through to older stages.
    function automatic logic [1:0] fwd_sel(input rec_t ex, input rec_t mem,
                                           input rec_t wb, input logic [4:0] src,
                                           input logic used);
        logic [1:0] sel;
        sel = 2'b00;
        if (used) begin
            if (hit(ex, src) && !ex.load) sel = 2'b01;
            else if (hit(mem, src))       sel = 2'b10;
            else if (hit(wb, src))        sel = 2'b11;
        end
        return sel;
    endfunction

    always_comb begin
        load_use  = ex_q.load && ((id_use_rs && hit(ex_q, id_rs)) ||
                                  (id_use_rt && hit(ex_q, id_rt)));
        hilo_wait = div_busy && id_uses_hilo;
        stall     = load_use || hilo_wait;
    end

    assign div_busy = (cnt_q != '0);
    assign fwd_a    = fwd_sel(ex_q, mem_q, wb_q, id_rs, id_use_rs);
    assign fwd_b    = fwd_sel(ex_q, mem_q, wb_q, id_rt, id_use_rt);

    // A stalled or flushed ID instruction does not enter EX. It therefore
    // cannot start the divider either.
    assign div_start = id_is_div && !stall && !flush;

    always_comb begin
        ex_d = '0;
        if (!stall && !flush) ex_d = '{dest: id_dest, wen: id_wen, load: id_is_load};

        cnt_d = cnt_q;
        if (div_start)      cnt_d = DIV_LOAD;
        else if (div_busy)  cnt_d = cnt_q - CNT_ONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
            cnt_q <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= ex_q;
            wb_q  <= mem_q;
            cnt_q <= cnt_d;
        end
    end

    assign ex_dest  = ex_q.dest;
    assign mem_dest = mem_q.dest;
    assign wb_dest  = wb_q.dest;
    assign wb_wen   = wb_q.wen;

endmodule
